// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decode plus iterative multiply/divide unit.
// HI/LO registers, stall handshake toward the hazard unit.
module alu_ctrl_mdu #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [5:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [3:0]        ALUCtrl_o,
  output logic [1:0]        res_sel_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              done_o,
  output logic              div_zero_o
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t st, st_nxt;

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] p_hi;
  logic [DATA_W-1:0] p_lo;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              neg_lo;
  logic              neg_hi;
  logic              dz_q;

  logic              mdu_op;
  logic              is_div;
  logic              is_sgn;
  logic              start;
  logic              dz_start;
  logic              last;
  logic              s1_neg;
  logic              s2_neg;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;

  logic [DATA_W:0]     m_sum;
  logic [DATA_W:0]     d_sh;
  logic                d_ge;
  logic [DATA_W-1:0]   d_sub;
  logic [DATA_W-1:0]   s_hi;
  logic [DATA_W-1:0]   s_lo;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_n;
  logic [DATA_W-1:0]   fin_hi;
  logic [DATA_W-1:0]   fin_lo;

  assign mdu_op   = (ALUOp_i == 3'b010) && (funct_i[5:2] == 4'b0110);
  assign is_div   = funct_i[1];
  assign is_sgn   = !funct_i[0];
  assign start    = (st == IDLE) && valid_i && mdu_op && !flush_i;
  assign dz_start = start && is_div && (src2_i == '0);
  assign last     = cnt == CW'(DATA_W - 1);

  assign s1_neg = is_sgn && src1_i[DATA_W-1];
  assign s2_neg = is_sgn && src2_i[DATA_W-1];
  assign mag1   = s1_neg ? -src1_i : src1_i;
  assign mag2   = s2_neg ? -src2_i : src2_i;

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // ALU operation decode from main-control opcode and funct
  always_comb begin
    ALUCtrl_o = 4'b1111;
    res_sel_o = 2'b00;
    case (ALUOp_i)
      3'b000: ALUCtrl_o = 4'b0010;
      3'b001: ALUCtrl_o = 4'b0110;
      3'b011: ALUCtrl_o = 4'b0010;
      3'b100: ALUCtrl_o = 4'b0111;
      3'b101: ALUCtrl_o = 4'b0000;
      3'b110: ALUCtrl_o = 4'b0001;
      3'b111: ALUCtrl_o = 4'b1010;
      3'b010: begin
        case (funct_i)
          6'b100000: ALUCtrl_o = 4'b0010;
          6'b100010: ALUCtrl_o = 4'b0110;
          6'b100100: ALUCtrl_o = 4'b0000;
          6'b100101: ALUCtrl_o = 4'b0001;
          6'b100111: ALUCtrl_o = 4'b1100;
          6'b101010: ALUCtrl_o = 4'b0111;
          6'b000000: ALUCtrl_o = 4'b1000;
          6'b000010: ALUCtrl_o = 4'b1001;
          6'b010000: res_sel_o = 2'b01;
          6'b010010: res_sel_o = 2'b10;
          default:   ALUCtrl_o = 4'b1111;
        endcase
      end
      default: ALUCtrl_o = 4'b1111;
    endcase
  end

  // One shift-add or restoring-divide step and the sign-corrected result
  always_comb begin
    m_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);
    d_sh  = {p_hi, p_lo[DATA_W-1]};
    d_ge  = d_sh[DATA_W] || (d_sh[DATA_W-1:0] >= a_q);
    d_sub = d_sh[DATA_W-1:0] - a_q;
    if (st == DIV) begin
      s_hi = d_ge ? d_sub : d_sh[DATA_W-1:0];
      s_lo = {p_lo[DATA_W-2:0], d_ge};
    end else begin
      s_hi = m_sum[DATA_W:1];
      s_lo = {m_sum[0], p_lo[DATA_W-1:1]};
    end
    prod   = {s_hi, s_lo};
    prod_n = neg_lo ? -prod : prod;
    if (st == DIV) begin
      fin_hi = neg_hi ? -s_hi : s_hi;
      fin_lo = neg_lo ? -s_lo : s_lo;
    end else begin
      fin_hi = prod_n[2*DATA_W-1:DATA_W];
      fin_lo = prod_n[DATA_W-1:0];
    end
  end

  // MDU state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) st <= IDLE;
    else        st <= st_nxt;
  end

  // MDU next-state logic
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (dz_start)   st_nxt = FIN;
        else if (start) st_nxt = is_div ? DIV : MUL;
      end
      MUL, DIV: begin
        if (flush_i)   st_nxt = IDLE;
        else if (last) st_nxt = FIN;
      end
      FIN:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // MDU outputs: stall toward hazard unit, completion pulses
  always_comb begin
    stall_o    = 1'b0;
    done_o     = (st == FIN);
    div_zero_o = (st == FIN) && dz_q;
    if (rst_i && !flush_i) begin
      case (st)
        IDLE:     stall_o = valid_i && mdu_op;
        MUL, DIV: stall_o = 1'b1;
        default:  stall_o = 1'b0;
      endcase
    end
  end

  // Operand latch, iteration datapath and HI/LO update
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      a_q    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz_q   <= 1'b0;
    end else if (st == IDLE) begin
      cnt <= '0;
      if (start) begin
        a_q    <= mag2;
        p_hi   <= '0;
        p_lo   <= mag1;
        neg_lo <= s1_neg ^ s2_neg;
        neg_hi <= s1_neg;
        dz_q   <= dz_start;
        if (dz_start) begin
          hi_q <= src1_i;
          lo_q <= '1;
        end
      end
    end else if (st == MUL || st == DIV) begin
      cnt  <= cnt + 1'b1;
      p_hi <= s_hi;
      p_lo <= s_lo;
      if (last && !flush_i) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Testbench for alu_ctrl_mdu: decode table, MDU results,
// stall timing, flush/reset aborts and an 8-bit instance.
module tb_alu_ctrl_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid;
  logic        flush;
  logic [5:0]  funct;
  logic [2:0]  aluop;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [3:0]  ctrl;
  logic [1:0]  sel;
  logic        stall;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        v8;
  logic        fl8;
  logic [5:0]  f8;
  logic [2:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [3:0]  c8;
  logic [1:0]  sl8;
  logic        st8;
  logic        dn8;
  logic        dz8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int tests = 0;
  int fails = 0;

  alu_ctrl_mdu #(.DATA_W(32)) u32 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
    .funct_i(funct), .ALUOp_i(aluop), .src1_i(s1), .src2_i(s2),
    .ALUCtrl_o(ctrl), .res_sel_o(sel), .stall_o(stall),
    .hi_o(hi), .lo_o(lo), .done_o(done), .div_zero_o(dz)
  );

  alu_ctrl_mdu #(.DATA_W(8)) u8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8), .flush_i(fl8),
    .funct_i(f8), .ALUOp_i(op8), .src1_i(a8), .src2_i(b8),
    .ALUCtrl_o(c8), .res_sel_o(sl8), .stall_o(st8),
    .hi_o(hi8), .lo_o(lo8), .done_o(dn8), .div_zero_o(dz8)
  );

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic [1:0] sel;
  } dec_t;

  dec_t vec[24];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run32(string nm, logic [5:0] fn, logic [31:0] a,
                       logic [31:0] b, int en, logic [31:0] eh,
                       logic [31:0] el, logic edz);
    int n;
    @(posedge clk); #1;
    valid = 1'b1;
    aluop = 3'b010;
    funct = fn;
    s1    = a;
    s2    = b;
    n     = 0;
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " stall cycles"}, n, en);
    chk({nm, " done"}, done, 1'b1);
    chk({nm, " div_zero"}, dz, edz);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    @(posedge clk); #1;
    funct = 6'b010010;
    @(negedge clk);
    chk({nm, " mflo sel"}, sel, 2'b10);
    chk({nm, " mflo ctrl"}, ctrl, 4'b1111);
    chk({nm, " mflo stall"}, stall, 1'b0);
    chk({nm, " mflo lo"}, lo, el);
    chk({nm, " done pulse"}, done, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    int n;
    vec[0]  = '{3'b000, 6'b100000, 4'b0010, 2'b00};
    vec[1]  = '{3'b001, 6'b000000, 4'b0110, 2'b00};
    vec[2]  = '{3'b011, 6'b101010, 4'b0010, 2'b00};
    vec[3]  = '{3'b100, 6'b000000, 4'b0111, 2'b00};
    vec[4]  = '{3'b101, 6'b000000, 4'b0000, 2'b00};
    vec[5]  = '{3'b110, 6'b000000, 4'b0001, 2'b00};
    vec[6]  = '{3'b111, 6'b000000, 4'b1010, 2'b00};
    vec[7]  = '{3'b010, 6'b100000, 4'b0010, 2'b00};
    vec[8]  = '{3'b010, 6'b100010, 4'b0110, 2'b00};
    vec[9]  = '{3'b010, 6'b100100, 4'b0000, 2'b00};
    vec[10] = '{3'b010, 6'b100101, 4'b0001, 2'b00};
    vec[11] = '{3'b010, 6'b100111, 4'b1100, 2'b00};
    vec[12] = '{3'b010, 6'b101010, 4'b0111, 2'b00};
    vec[13] = '{3'b010, 6'b000000, 4'b1000, 2'b00};
    vec[14] = '{3'b010, 6'b000010, 4'b1001, 2'b00};
    vec[15] = '{3'b010, 6'b010000, 4'b1111, 2'b01};
    vec[16] = '{3'b010, 6'b010010, 4'b1111, 2'b10};
    vec[17] = '{3'b010, 6'b011000, 4'b1111, 2'b00};
    vec[18] = '{3'b010, 6'b011001, 4'b1111, 2'b00};
    vec[19] = '{3'b010, 6'b011010, 4'b1111, 2'b00};
    vec[20] = '{3'b010, 6'b011011, 4'b1111, 2'b00};
    vec[21] = '{3'b010, 6'b111111, 4'b1111, 2'b00};
    vec[22] = '{3'b010, 6'b100001, 4'b1111, 2'b00};
    vec[23] = '{3'b001, 6'b010000, 4'b0110, 2'b00};

    rst   = 1'b0;
    valid = 1'b1;
    flush = 1'b0;
    aluop = 3'b010;
    funct = 6'b011000;
    s1    = 32'd3;
    s2    = 32'd4;
    v8    = 1'b0;
    fl8   = 1'b0;
    f8    = 6'b000000;
    op8   = 3'b000;
    a8    = 8'd0;
    b8    = 8'd0;
    #11;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset done", done, 1'b0);
    chk("reset div_zero", dz, 1'b0);
    chk("reset stall", stall, 1'b0);
    valid = 1'b0;
    #1 rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      aluop = vec[i].op;
      funct = vec[i].fn;
      #1;
      chk($sformatf("decode[%0d] ctrl", i), ctrl, vec[i].ctrl);
      chk($sformatf("decode[%0d] sel", i), sel, vec[i].sel);
    end

    run32("mult -3*7", 6'b011000, 32'hFFFFFFFD, 32'd7, 33,
          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run32("multu max", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
          32'hFFFFFFFE, 32'h00000001, 1'b0);
    run32("mult minneg", 6'b011000, 32'h80000000, 32'h80000000, 33,
          32'h40000000, 32'h00000000, 1'b0);
    run32("divu 100/7", 6'b011011, 32'd100, 32'd7, 33,
          32'd2, 32'd14, 1'b0);
    run32("div -7/2", 6'b011010, 32'hFFFFFFF9, 32'd2, 33,
          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run32("div 7/-2", 6'b011010, 32'd7, 32'hFFFFFFFE, 33,
          32'd1, 32'hFFFFFFFD, 1'b0);
    run32("div 5/0", 6'b011010, 32'd5, 32'd0, 1,
          32'd5, 32'hFFFFFFFF, 1'b1);
    run32("preload", 6'b011011, 32'd5, 32'd2, 33,
          32'd1, 32'd2, 1'b0);

    @(posedge clk); #1;
    valid = 1'b1;
    aluop = 3'b010;
    funct = 6'b011001;
    s1    = 32'h1234;
    s2    = 32'h5678;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("flush pre stall", stall, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush stall drop", stall, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    funct = 6'b010000;
    @(negedge clk);
    chk("flush idle stall", stall, 1'b0);
    chk("flush mfhi sel", sel, 2'b01);
    chk("flush hi kept", hi, 32'd1);
    chk("flush no done", done, 1'b0);
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("flush done count", n, 0);
    chk("flush lo kept", lo, 32'd2);

    @(posedge clk); #1;
    valid = 1'b1;
    funct = 6'b011001;
    s1    = 32'd9;
    s2    = 32'd9;
    repeat (3) @(posedge clk);
    #1;
    funct = 6'b010000;
    @(negedge clk);
    chk("mfhi in MUL stall", stall, 1'b1);
    chk("mfhi in MUL sel", sel, 2'b01);
    @(posedge clk); #1;
    funct = 6'b011001;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst stall", stall, 1'b0);
    chk("rst done", done, 1'b0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run32("div 5/0 again", 6'b011010, 32'd5, 32'd0, 1,
          32'd5, 32'hFFFFFFFF, 1'b1);

    @(posedge clk); #1;
    v8  = 1'b1;
    op8 = 3'b010;
    f8  = 6'b011001;
    a8  = 8'hFF;
    b8  = 8'hFF;
    n   = 0;
    @(negedge clk);
    while (st8 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("w8 stall cycles", n, 9);
    chk("w8 done", dn8, 1'b1);
    chk("w8 div_zero", dz8, 1'b0);
    chk("w8 hi", hi8, 8'hFE);
    chk("w8 lo", lo8, 8'h01);
    chk("w8 ctrl", c8, 4'b1111);
    chk("w8 sel", sl8, 2'b00);
    @(posedge clk); #1;
    v8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
